// File: rtl/clk_div_pkg.sv
// Shared defaults and channel-state layout for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_DIV   = 9000000;

  // Per-channel state at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_CNT_W-1:0] div_act;
    logic [DEF_CNT_W-1:0] div_pend;
    logic                 pend;
  } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor, sclk and tick flops.
// A new divisor is applied only at a terminal count or while stopped.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEF_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             sclk,
  output logic             tick,
  output logic             pend
);

  // Same layout as chan_state_t, sized by this instance's CNT_W.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic             pend;
  } state_t;

  state_t st;
  logic   sclk_q;
  logic   tick_q;
  logic   at_term;
  logic   apply;

  assign at_term = (st.count == st.div_act);
  assign apply   = st.pend & (~en | at_term);

  // NOTE: div_pend is deliberately left out of reset; pend guards it, so its
  // contents are never observed until a write has loaded it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st.count   <= '0;
      st.div_act <= DEFAULT_DIV;
      st.pend    <= 1'b0;
      sclk_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      if (en) begin
        if (at_term) begin
          st.count <= '0;
          sclk_q   <= ~sclk_q;
          tick_q   <= 1'b1;
        end else begin
          st.count <= st.count + 1'b1;
          tick_q   <= 1'b0;
        end
      end else begin
        st.count <= '0;
        sclk_q   <= 1'b0;
        tick_q   <= 1'b0;
      end

      // Divisor swaps only when count returns to zero, so no runt half-periods.
      if (apply) begin
        st.div_act <= st.div_pend;
        st.pend    <= 1'b0;
      end

      if (wr) begin
        st.div_pend <= wr_div;
        st.pend     <= 1'b1;
      end
    end
  end

  assign sclk = sclk_q;
  assign tick = tick_q;
  assign pend = st.pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode and ready muxing
// around NUM_CH independent clk_div_chan instances.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int DEFAULT_DIV = DEF_DIV,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;

  // NOTE: both outputs get a default before the loop so no latch is inferred.
  // Out-of-range channels keep cfg_ready high and the write is simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend[i];
        wr[i]     = cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (en[g]),
      .wr     (wr[g]),
      .wr_div (cfg_div),
      .sclk   (sclk[g]),
      .tick   (tick[g]),
      .pend   (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a deadline-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_clk_div_multi;

  localparam int DDIV = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] en = 4'h0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_ready3;
  logic [3:0] sclk, tick;
  logic [2:0] sclk3, tick3;

  always #5 clk = ~clk;

  clk_div_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .sclk(sclk), .tick(tick)
  );

  // Three-channel build shares stimulus; cfg_ch=3 is out of range for it.
  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(DDIV)) dut3 (
    .clk(clk), .reset(reset), .en(en[2:0]), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready3), .sclk(sclk3), .tick(tick3)
  );

  typedef struct { int tag; logic [3:0] sclk; logic [3:0] tick; } out_t;
  typedef struct { int tag; bit chk; logic r4; logic r3; } rdy_t;

  out_t out_q[$];
  rdy_t rdy_q[$];

  int edge_cnt = 0;
  int checks   = 0;
  int failures = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: each channel knows the absolute edge of its next toggle.
  int m_div [4];
  int m_pdiv[4];
  bit m_pend[4];
  bit m_sclk[4];
  bit m_tick[4];
  int m_next[4];
  bit m_init = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] e, input logic v,
                       input logic [1:0] ch, input logic [7:0] d);
    int   k;
    bit   acc;
    rdy_t ry;
    out_t ot;
    @(posedge clk);
    #1;
    reset = r; en = e; cfg_valid = v; cfg_ch = ch; cfg_div = d;

    ry.tag = edge_cnt;
    ry.chk = m_init;
    ry.r4  = !m_pend[ch];
    ry.r3  = (ch == 2'd3) ? 1'b1 : !m_pend[ch];
    rdy_q.push_back(ry);

    acc = v && !m_pend[ch];
    k   = edge_cnt + 1;
    if (r) begin
      m_init = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_div[i] = DDIV; m_pend[i] = 1'b0; m_sclk[i] = 1'b0; m_tick[i] = 1'b0;
        m_next[i] = k + 1 + DDIV;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (e[i]) begin
          if (k == m_next[i]) begin
            m_sclk[i] = !m_sclk[i];
            m_tick[i] = 1'b1;
            if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
            m_next[i] = k + m_div[i] + 1;
          end else begin
            m_tick[i] = 1'b0;
          end
        end else begin
          m_sclk[i] = 1'b0;
          m_tick[i] = 1'b0;
          if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
          m_next[i] = k + 1 + m_div[i];
        end
      end
      if (acc) begin
        m_pdiv[ch] = int'(d);
        m_pend[ch] = 1'b1;
      end
    end

    ot.tag = k;
    for (int i = 0; i < 4; i++) begin
      ot.sclk[i] = m_sclk[i];
      ot.tick[i] = m_tick[i];
    end
    out_q.push_back(ot);
  endtask

  task automatic idle(input int n, input logic [3:0] e);
    repeat (n) drive(1'b0, e, 1'b0, 2'd0, 8'd0);
  endtask

  // Monitor: compares whatever expectation is due after the latest edge.
  initial begin
    out_t o;
    rdy_t ry;
    forever begin
      @(negedge clk);
      if (out_q.size() > 0 && out_q[0].tag == edge_cnt) begin
        o = out_q.pop_front();
        check("sclk",  8'(sclk),  8'(o.sclk));
        check("tick",  8'(tick),  8'(o.tick));
        check("sclk3", 8'(sclk3), 8'(o.sclk[2:0]));
        check("tick3", 8'(tick3), 8'(o.tick[2:0]));
      end
      if (rdy_q.size() > 0 && rdy_q[0].tag == edge_cnt) begin
        ry = rdy_q.pop_front();
        if (ry.chk) begin
          check("cfg_ready",  8'(cfg_ready),  8'(ry.r4));
          check("cfg_ready3", 8'(cfg_ready3), 8'(ry.r3));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;
    // Reset then free-run at the default divisor.
    repeat (3) drive(1'b1, 4'hF, 1'b0, 2'd0, 8'd0);
    idle(40, 4'hF);

    // Mid-period write to ch1, rejected repeat while pending, ch0 still accepted.
    idle(2, 4'hF);
    drive(1'b0, 4'hF, 1'b1, 2'd1, 8'd1);
    drive(1'b0, 4'hF, 1'b1, 2'd1, 8'd5);
    drive(1'b0, 4'hF, 1'b1, 2'd0, 8'd3);
    idle(20, 4'hF);

    // Stopped ch2 takes div=0 immediately, then toggles every cycle.
    idle(3, 4'b1011);
    drive(1'b0, 4'b1011, 1'b1, 2'd2, 8'd0);
    idle(2, 4'b1011);
    idle(12, 4'hF);

    // ch3 write: real on the 4-channel build, discarded on the 3-channel one.
    drive(1'b0, 4'hF, 1'b1, 2'd3, 8'd0);
    idle(10, 4'hF);
    drive(1'b0, 4'hF, 1'b1, 2'd3, 8'd3);
    idle(10, 4'hF);

    // Reset while ch0 holds a pending div=7.
    drive(1'b0, 4'hF, 1'b1, 2'd0, 8'd7);
    idle(1, 4'hF);
    repeat (2) drive(1'b1, 4'hF, 1'b0, 2'd0, 8'd0);
    idle(20, 4'hF);

    // Drop en[3] mid-period, then re-enable.
    idle(2, 4'hF);
    idle(3, 4'b0111);
    idle(12, 4'hF);

    // Randomized traffic.
    e = 4'hF;
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) e[$urandom_range(0, 3)] = ~e[$urandom_range(0, 3)];
      drive(($urandom_range(0, 199) == 0), e, ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)));
    end
    idle(3, e);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", 8'(out_q.size() + rdy_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
